// File: rtl/lsu_rmw_if.sv
// MEM-stage request/response and word-RAM data port of the load/store unit.
// slave = lsu_rmw side, master = MEM stage plus RAM.
`ifndef XLEN
`define XLEN 32
`endif

interface lsu_rmw_if #(
  parameter int XLEN = `XLEN
) ();
  logic            req_i;
  logic            we_i;
  logic [1:0]      size_i;
  logic            unsigned_i;
  logic [XLEN-1:0] addr_i;
  logic [XLEN-1:0] wdata_i;
  logic            ready_o;
  logic            valid_o;
  logic            err_o;
  logic [XLEN-1:0] rdata_o;
  logic            ram_req_o;
  logic            ram_we_o;
  logic [XLEN-1:0] ram_addr_o;
  logic [XLEN-1:0] ram_data_o;
  logic [XLEN-1:0] ram_data_i;

  modport slave (
    input  req_i, we_i, size_i, unsigned_i, addr_i, wdata_i, ram_data_i,
    output ready_o, valid_o, err_o, rdata_o,
    output ram_req_o, ram_we_o, ram_addr_o, ram_data_o
  );

  modport master (
    output req_i, we_i, size_i, unsigned_i, addr_i, wdata_i, ram_data_i,
    input  ready_o, valid_o, err_o, rdata_o,
    input  ram_req_o, ram_we_o, ram_addr_o, ram_data_o
  );
endinterface

// File: rtl/lsu_rmw.sv
// Byte/half/word load-store unit over a big-endian word RAM; latency load 2, word store 2, sub-word store 3, error 1.
// One access in flight: ready_o low while busy, req_i ignored. LSU_RANGE_CHECK_EN rejects addresses above RAM_ADDR_WIDTH.
`ifndef XLEN
`define XLEN 32
`endif

module lsu_rmw #(
  parameter int RAM_ADDR_WIDTH = 20,
  parameter int XLEN           = `XLEN
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  lsu_rmw_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] WR   = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  typedef struct packed {
    logic            we;
    logic [1:0]      size;
    logic            uns;
    logic            err;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } req_t;

  logic [1:0]      state_q;
  req_t            req_q;
  logic [XLEN-1:0] word_q;
  logic [XLEN-1:0] rdata_q;

  logic            range_err;
  logic            acc_err;
  logic [7:0]      lane8;
  logic [15:0]     lane16;
  logic [XLEN-1:0] load_ext;
  logic [XLEN-1:0] merged;

`ifdef LSU_RANGE_CHECK_EN
  assign range_err = |bus.addr_i[XLEN-1:RAM_ADDR_WIDTH];
`else
  logic unused_range_bits;
  assign unused_range_bits = |bus.addr_i[XLEN-1:RAM_ADDR_WIDTH];
  assign range_err         = 1'b0;
`endif

  assign acc_err = (bus.size_i == 2'b11)
                 | ((bus.size_i == 2'b01) & bus.addr_i[0])
                 | ((bus.size_i == 2'b10) & (|bus.addr_i[1:0]))
                 | range_err;

  // Lane extraction uses the live RAM word so rdata lands on the same edge as word_q.
  always_comb begin
    lane8 = 8'h00;
    case (req_q.addr[1:0])
      2'd0: lane8 = bus.ram_data_i[31:24];
      2'd1: lane8 = bus.ram_data_i[23:16];
      2'd2: lane8 = bus.ram_data_i[15:8];
      2'd3: lane8 = bus.ram_data_i[7:0];
      default: lane8 = 8'h00;
    endcase
    lane16 = req_q.addr[1] ? bus.ram_data_i[15:0] : bus.ram_data_i[31:16];
    case (req_q.size)
      2'b00:   load_ext = {{24{~req_q.uns & lane8[7]}}, lane8};
      2'b01:   load_ext = {{16{~req_q.uns & lane16[15]}}, lane16};
      default: load_ext = bus.ram_data_i;
    endcase
  end

  always_comb begin
    merged = req_q.wdata;
    if (req_q.size == 2'b00) begin
      case (req_q.addr[1:0])
        2'd0: merged = {req_q.wdata[7:0], word_q[23:0]};
        2'd1: merged = {word_q[31:24], req_q.wdata[7:0], word_q[15:0]};
        2'd2: merged = {word_q[31:16], req_q.wdata[7:0], word_q[7:0]};
        2'd3: merged = {word_q[31:8], req_q.wdata[7:0]};
        default: merged = req_q.wdata;
      endcase
    end else if (req_q.size == 2'b01) begin
      merged = req_q.addr[1] ? {word_q[31:16], req_q.wdata[15:0]}
                             : {req_q.wdata[15:0], word_q[15:0]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      req_q   <= '0;
      word_q  <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_i) begin
            req_q <= '{we: bus.we_i, size: bus.size_i, uns: bus.unsigned_i,
                       err: acc_err, addr: bus.addr_i, wdata: bus.wdata_i};
            if (acc_err)
              state_q <= RESP;
            else if (bus.we_i && (bus.size_i == 2'b10))
              state_q <= WR;
            else
              state_q <= RD;
          end
        end
        RD: begin
          word_q <= bus.ram_data_i;
          if (req_q.we) begin
            state_q <= WR;
          end else begin
            rdata_q <= load_ext;
            state_q <= RESP;
          end
        end
        WR:      state_q <= RESP;
        default: state_q <= IDLE;
      endcase
    end
  end

  // All outputs decode from state so an async reset drops ram_we_o immediately.
  assign bus.ready_o    = (state_q == IDLE);
  assign bus.valid_o    = (state_q == RESP);
  assign bus.err_o      = (state_q == RESP) & req_q.err;
  assign bus.rdata_o    = rdata_q;
  assign bus.ram_req_o  = (state_q == RD) | (state_q == WR);
  assign bus.ram_we_o   = (state_q == WR);
  assign bus.ram_addr_o = bus.ram_req_o ? {req_q.addr[XLEN-1:2], 2'b00} : '0;
  assign bus.ram_data_o = (state_q == WR) ? merged : '0;

endmodule

// File: tb/tb_lsu_rmw.sv
// Directed bench for lsu_rmw: byte-level reference model plus per-cycle compare process.
module tb_lsu_rmw;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_rmw_if #(.XLEN(XLEN)) bus ();
  lsu_rmw #(.RAM_ADDR_WIDTH(20), .XLEN(XLEN)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

  // Word RAM: combinational read, write on clock edge, backdoor preload port.
  logic [31:0] ram [0:1023];
  logic        pl_en = 1'b0;
  logic [9:0]  pl_idx = '0;
  logic [31:0] pl_val = '0;
  always @(posedge clk) begin
    if (pl_en) ram[pl_idx] <= pl_val;
    else if (bus.ram_req_o && bus.ram_we_o) ram[bus.ram_addr_o[11:2]] <= bus.ram_data_o;
  end
  assign bus.ram_data_i = ram[bus.ram_addr_o[11:2]];

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  // Reference model state, written only by the stimulus process.
  logic [31:0] ref_mem [0:1023];
  int          n_issued = 0;
  int          exp_lat, exp_nreq, exp_nwr;
  logic        exp_err, exp_load;
  logic [31:0] exp_rd, exp_waddr, exp_wdata;

  function automatic void predict(input logic we, input logic [1:0] sz, input logic uns,
                                  input logic [31:0] a, input logic [31:0] wd);
    int n, off;
    logic [7:0] b [4];
    logic [31:0] w;
    longint v;
    logic e;
    n   = 1 << sz;
    off = int'(a % 4);
    e   = (sz == 2'b11) || ((a % n) != 0);
`ifdef LSU_RANGE_CHECK_EN
    if (a >= 32'h0010_0000) e = 1'b1;
`endif
    w = ref_mem[a[11:2]];
    for (int i = 0; i < 4; i++) b[i] = w[31-8*i -: 8];
    exp_err   = e;
    exp_load  = !we;
    exp_waddr = {a[31:2], 2'b00};
    exp_lat   = e ? 1 : ((!we || n == 4) ? 2 : 3);
    exp_nreq  = e ? 0 : ((we && n < 4) ? 2 : 1);
    exp_nwr   = (!e && we) ? 1 : 0;
    exp_rd    = '0;
    exp_wdata = '0;
    if (!e && !we) begin
      v = 0;
      for (int i = 0; i < n; i++) v = (v << 8) | longint'(b[off+i]);
      if (!uns && v[8*n-1]) v = v - (64'sd1 <<< (8*n));
      exp_rd = v[31:0];
    end else if (!e) begin
      for (int i = 0; i < n; i++) b[off+i] = wd[8*(n-1-i) +: 8];
      w = {b[0], b[1], b[2], b[3]};
      ref_mem[a[11:2]] = w;
      exp_wdata = w;
    end
  endfunction

  // Compare process: checks outputs on every falling edge.
  int          n_done = 0;
  int          k = 0, seen_req = 0, seen_wr = 0;
  logic [31:0] hold_rd = '0;
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      n_done = n_issued; k = 0; seen_req = 0; seen_wr = 0; hold_rd = '0;
    end else begin
      if (n_issued != n_done) begin
        k++;
        check1("busy_ready", bus.ready_o, 1'b0);
        if (bus.ram_req_o) seen_req++;
        if (bus.ram_we_o) begin
          seen_wr++;
          check("wr_addr", bus.ram_addr_o, exp_waddr);
          check("wr_data", bus.ram_data_o, exp_wdata);
        end
        if (bus.valid_o) begin
          check("latency", 32'(k), 32'(exp_lat));
          check1("err", bus.err_o, exp_err);
          check("ram_req_cycles", 32'(seen_req), 32'(exp_nreq));
          check("ram_wr_cycles", 32'(seen_wr), 32'(exp_nwr));
          if (exp_load && !exp_err) hold_rd = exp_rd;
          n_done++; k = 0; seen_req = 0; seen_wr = 0;
        end else if (k > exp_lat) begin
          check1("valid_timeout", bus.valid_o, 1'b1);
          n_done++; k = 0; seen_req = 0; seen_wr = 0;
        end
      end else begin
        check1("idle_ready", bus.ready_o, 1'b1);
        check1("idle_valid", bus.valid_o, 1'b0);
        check1("idle_ram_req", bus.ram_req_o, 1'b0);
      end
      check("rdata_o", bus.rdata_o, hold_rd);
    end
  end

  task automatic preload(input logic [31:0] a, input logic [31:0] val);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = a[11:2]; pl_val = val;
    ref_mem[a[11:2]] = val;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
    int t;
    t = 0;
    @(negedge clk);
    bus.req_i = 1'b1; bus.we_i = we; bus.size_i = sz; bus.unsigned_i = uns;
    bus.addr_i = a; bus.wdata_i = wd;
    while (!bus.ready_o && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!bus.ready_o) begin
      check1("accept_timeout", bus.ready_o, 1'b1);
      bus.req_i = 1'b0;
    end else begin
      @(posedge clk); #1;
      bus.req_i = 1'b0;
      predict(we, sz, uns, a, wd);
      n_issued++;
    end
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (n_done != n_issued && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (n_done != n_issued) check("done_timeout", 32'(n_done), 32'(n_issued));
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_i = 1'b0; bus.we_i = 1'b0; bus.size_i = 2'b00; bus.unsigned_i = 1'b0;
    bus.addr_i = '0; bus.wdata_i = '0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
    repeat (2) @(negedge clk);
    check1("rst_ready", bus.ready_o, 1'b1);
    check1("rst_valid", bus.valid_o, 1'b0);
    check1("rst_err", bus.err_o, 1'b0);
    check("rst_rdata", bus.rdata_o, 32'h0);
    check1("rst_ram_req", bus.ram_req_o, 1'b0);
    check1("rst_ram_we", bus.ram_we_o, 1'b0);
    check("rst_ram_addr", bus.ram_addr_o, 32'h0);
    check("rst_ram_data", bus.ram_data_o, 32'h0);
    rst_n = 1'b1;

    preload(32'h0, 32'hCAFEF00D);
    preload(32'h100, 32'h0);
    preload(32'h200, 32'h11223344);
    preload(32'h300, 32'h55667788);

    // Word store then load, back to back.
    issue(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF);
    issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    wait_done();
    check("lit_word_load", bus.rdata_o, 32'hDEADBEEF);
    check("lit_mem_100", ram[10'h40], 32'hDEADBEEF);

    // Byte RMW, then extension variants on the merged word.
    issue(1'b1, 2'b00, 1'b0, 32'h202, 32'h000000AA);
    wait_done();
    check("lit_rmw_byte", ram[10'h80], 32'h1122AA44);
    issue(1'b0, 2'b01, 1'b0, 32'h200, 32'h0);
    wait_done();
    check("lit_half_signed", bus.rdata_o, 32'h00001122);
    issue(1'b0, 2'b00, 1'b0, 32'h202, 32'h0);
    wait_done();
    check("lit_byte_signed", bus.rdata_o, 32'hFFFFFFAA);
    issue(1'b0, 2'b00, 1'b1, 32'h202, 32'h0);
    wait_done();
    check("lit_byte_unsigned", bus.rdata_o, 32'h000000AA);

    // Upper halfword store and lane 3 byte store.
    issue(1'b1, 2'b01, 1'b0, 32'h202, 32'h1234BEEF);
    issue(1'b0, 2'b01, 1'b0, 32'h202, 32'h0);
    wait_done();
    check("lit_mem_200_half", ram[10'h80], 32'h1122BEEF);
    check("lit_half_neg", bus.rdata_o, 32'hFFFFBEEF);
    issue(1'b1, 2'b00, 1'b0, 32'h103, 32'h0000005A);
    issue(1'b0, 2'b00, 1'b0, 32'h101, 32'h0);
    issue(1'b0, 2'b01, 1'b1, 32'h100, 32'h0);
    wait_done();
    check("lit_mem_100_b3", ram[10'h40], 32'hDEADBE5A);
    check("lit_half_unsigned", bus.rdata_o, 32'h0000DEAD);

    // Rejected accesses: no RAM traffic, memory and rdata_o untouched.
    issue(1'b0, 2'b01, 1'b0, 32'h101, 32'h0);
    issue(1'b1, 2'b10, 1'b0, 32'h102, 32'h12345678);
    issue(1'b0, 2'b11, 1'b0, 32'h100, 32'h0);
    issue(1'b1, 2'b01, 1'b0, 32'h203, 32'hFFFF);
    wait_done();
    check("lit_mem_100_kept", ram[10'h40], 32'hDEADBE5A);
    check("lit_mem_200_kept", ram[10'h80], 32'h1122BEEF);
    check("lit_rdata_kept", bus.rdata_o, 32'h0000DEAD);

    // Address above the RAM decode range.
    issue(1'b0, 2'b10, 1'b0, 32'h0010_0000, 32'h0);
    wait_done();
`ifdef LSU_RANGE_CHECK_EN
    check("lit_range_rdata", bus.rdata_o, 32'h0000DEAD);
`else
    check("lit_alias_rdata", bus.rdata_o, 32'hCAFEF00D);
`endif

    // Reset while the byte store to 0x300 sits in WR.
    issue(1'b1, 2'b00, 1'b0, 32'h300, 32'h00000099);
    @(posedge clk); #1;
    check1("pre_rst_we", bus.ram_we_o, 1'b1);
    rst_n = 1'b0;
    #1;
    check1("mid_rst_we", bus.ram_we_o, 1'b0);
    check1("mid_rst_req", bus.ram_req_o, 1'b0);
    check1("mid_rst_ready", bus.ready_o, 1'b1);
    check1("mid_rst_valid", bus.valid_o, 1'b0);
    check("mid_rst_addr", bus.ram_addr_o, 32'h0);
    check("mid_rst_data", bus.ram_data_o, 32'h0);
    check("mid_rst_rdata", bus.rdata_o, 32'h0);
    ref_mem[10'hC0] = 32'h55667788;
    repeat (2) @(negedge clk);
    check("lit_mem_300_kept", ram[10'hC0], 32'h55667788);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    issue(1'b0, 2'b10, 1'b0, 32'h300, 32'h0);
    wait_done();
    check("lit_post_rst_load", bus.rdata_o, 32'h55667788);
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
